tcam_lookup_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the TCAM wrapper in the blueswitch lookup path. It arbitrates control-plane entry writes against data-plane lookups, sequences write pulses and waits out the TCAM busy window, and pipelines lookup keys into the TCAM. Match results are captured into a 4-entry response FIFO with valid/ready back-pressure, and hit/miss statistics are maintained.

---
 rtl/tcam_lookup_ctrl.sv | 142 ++++++++++++++
 tb/tb_tcam_lookup_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_lookup_ctrl.sv
// rtl/tcam_lookup_ctrl.sv - TCAM request controller: write sequencing, lookup pipe, response FIFO, stats
// Writes wait for an empty lookup pipe; lookups are credit-limited so the 4-entry response FIFO never overflows.
module tcam_lookup_ctrl #(
  parameter int C_TCAM_ADDR_WIDTH = 4,
  parameter int C_TCAM_DATA_WIDTH = 16,
  parameter int C_TAG_WIDTH       = 8,
  parameter int C_MATCH_LATENCY   = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WR_REQ_VALID,
  output logic                         WR_REQ_READY,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] WR_REQ_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0] WR_REQ_DATA,
  input  logic [C_TCAM_DATA_WIDTH-1:0] WR_REQ_MASK,
  input  logic                         LU_REQ_VALID,
  output logic                         LU_REQ_READY,
  input  logic [C_TCAM_DATA_WIDTH-1:0] LU_REQ_KEY,
  input  logic [C_TAG_WIDTH-1:0]       LU_REQ_TAG,
  output logic                         LU_RSP_VALID,
  input  logic                         LU_RSP_READY,
  output logic                         LU_RSP_HIT,
  output logic [C_TCAM_ADDR_WIDTH-1:0] LU_RSP_ADDR,
  output logic [C_TAG_WIDTH-1:0]       LU_RSP_TAG,
  output logic                         TCAM_WE,
  output logic [C_TCAM_ADDR_WIDTH-1:0] TCAM_WR_ADDR,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DIN,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DATA_MASK,
  input  logic                         TCAM_BUSY,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_CMP_DIN,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_CMP_DATA_MASK,
  input  logic                         TCAM_MATCH,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] TCAM_MATCH_ADDR,
  output logic [31:0]                  HIT_COUNT,
  output logic [31:0]                  MISS_COUNT
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_ISSUE = 2'd1;
  localparam logic [1:0] S_WR_HOLD  = 2'd2;
  localparam logic [1:0] S_WR_WAIT  = 2'd3;
  localparam int RW = 1 + C_TCAM_ADDR_WIDTH + C_TAG_WIDTH;

  logic [1:0]                 state;
  logic [C_MATCH_LATENCY-1:0] pipe_vld;
  logic [C_TAG_WIDTH-1:0]     pipe_tag [C_MATCH_LATENCY];
  logic [RW-1:0]              fifo_mem [4];
  logic [1:0]                 rd_ptr;
  logic [1:0]                 wr_ptr;
  logic [2:0]                 fifo_count;
  logic [2:0]                 inflight;
  logic                       wr_fire;
  logic                       lu_fire;
  logic                       push;
  logic                       pop;
  logic [RW-1:0]              push_word;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < C_MATCH_LATENCY; i++)
      inflight = inflight + {2'b00, pipe_vld[i]};
  end

  assign WR_REQ_READY = !RESET && (state == S_IDLE) && WR_REQ_VALID &&
                        (inflight == 3'd0) && !TCAM_BUSY;
  // Credits cover both lookups still in the pipe and results already buffered.
  assign LU_REQ_READY = !RESET && (state == S_IDLE) && !WR_REQ_VALID && !TCAM_BUSY &&
                        (({1'b0, inflight} + {1'b0, fifo_count}) < 4'd4);

  assign wr_fire   = WR_REQ_VALID && WR_REQ_READY;
  assign lu_fire   = LU_REQ_VALID && LU_REQ_READY;
  assign push      = pipe_vld[C_MATCH_LATENCY-1];
  assign pop       = LU_RSP_VALID && LU_RSP_READY;
  assign push_word = {TCAM_MATCH, TCAM_MATCH ? TCAM_MATCH_ADDR : {C_TCAM_ADDR_WIDTH{1'b0}},
                      pipe_tag[C_MATCH_LATENCY-1]};

  assign LU_RSP_VALID = (fifo_count != 3'd0);
  assign {LU_RSP_HIT, LU_RSP_ADDR, LU_RSP_TAG} = fifo_mem[rd_ptr];
  assign TCAM_CMP_DATA_MASK = '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      TCAM_WE        <= 1'b0;
      TCAM_WR_ADDR   <= '0;
      TCAM_DIN       <= '0;
      TCAM_DATA_MASK <= '0;
    end else begin
      TCAM_WE <= wr_fire;
      if (wr_fire) begin
        TCAM_WR_ADDR   <= WR_REQ_ADDR;
        TCAM_DIN       <= WR_REQ_DATA;
        TCAM_DATA_MASK <= WR_REQ_MASK;
      end
      case (state)
        S_IDLE:     if (wr_fire) state <= S_WR_ISSUE;
        S_WR_ISSUE: state <= S_WR_HOLD;
        // BUSY may not rise until the cycle after the strobe, so it is not looked at here.
        S_WR_HOLD:  state <= S_WR_WAIT;
        S_WR_WAIT:  if (!TCAM_BUSY) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_vld     <= '0;
      TCAM_CMP_DIN <= '0;
      for (int i = 0; i < C_MATCH_LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= lu_fire;
      pipe_tag[0] <= LU_REQ_TAG;
      if (lu_fire) TCAM_CMP_DIN <= LU_REQ_KEY;
      for (int i = 1; i < C_MATCH_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + 2'd1;
        if (TCAM_MATCH) HIT_COUNT  <= HIT_COUNT + 32'd1;
        else            MISS_COUNT <= MISS_COUNT + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb/tb_tcam_lookup_ctrl.sv - randomized bench for tcam_lookup_ctrl with a behavioural TCAM and reference model
module tb_tcam_lookup_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TW = 8;
  typedef logic [AW+TW:0] rsp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, WR_REQ_VALID, WR_REQ_READY, LU_REQ_VALID, LU_REQ_READY;
  logic LU_RSP_VALID, LU_RSP_READY, LU_RSP_HIT, TCAM_WE, TCAM_BUSY, TCAM_MATCH;
  logic [AW-1:0] WR_REQ_ADDR, LU_RSP_ADDR, TCAM_WR_ADDR, TCAM_MATCH_ADDR;
  logic [DW-1:0] WR_REQ_DATA, WR_REQ_MASK, LU_REQ_KEY, TCAM_DIN, TCAM_DATA_MASK;
  logic [DW-1:0] TCAM_CMP_DIN, TCAM_CMP_DATA_MASK;
  logic [TW-1:0] LU_REQ_TAG, LU_RSP_TAG;
  logic [31:0]   HIT_COUNT, MISS_COUNT;

  tcam_lookup_ctrl #(.C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW), .C_TAG_WIDTH(TW),
                     .C_MATCH_LATENCY(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_REQ_VALID(WR_REQ_VALID), .WR_REQ_READY(WR_REQ_READY), .WR_REQ_ADDR(WR_REQ_ADDR),
    .WR_REQ_DATA(WR_REQ_DATA), .WR_REQ_MASK(WR_REQ_MASK),
    .LU_REQ_VALID(LU_REQ_VALID), .LU_REQ_READY(LU_REQ_READY), .LU_REQ_KEY(LU_REQ_KEY),
    .LU_REQ_TAG(LU_REQ_TAG), .LU_RSP_VALID(LU_RSP_VALID), .LU_RSP_READY(LU_RSP_READY),
    .LU_RSP_HIT(LU_RSP_HIT), .LU_RSP_ADDR(LU_RSP_ADDR), .LU_RSP_TAG(LU_RSP_TAG),
    .TCAM_WE(TCAM_WE), .TCAM_WR_ADDR(TCAM_WR_ADDR), .TCAM_DIN(TCAM_DIN),
    .TCAM_DATA_MASK(TCAM_DATA_MASK), .TCAM_BUSY(TCAM_BUSY), .TCAM_CMP_DIN(TCAM_CMP_DIN),
    .TCAM_CMP_DATA_MASK(TCAM_CMP_DATA_MASK), .TCAM_MATCH(TCAM_MATCH),
    .TCAM_MATCH_ADDR(TCAM_MATCH_ADDR), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  // Behavioural TCAM: lowest matching valid entry wins, busy for busy_len cycles after each write.
  logic [DW-1:0] m_data [16];
  logic [DW-1:0] m_mask [16];
  logic          m_vld  [16];
  int            busy_len = 0;
  int            busy_cnt = 0;
  assign TCAM_BUSY = (busy_cnt != 0);

  initial for (int i = 0; i < 16; i++) begin m_vld[i] = 1'b0; m_data[i] = '0; m_mask[i] = '0; end

  always @(posedge CLK) begin
    if (TCAM_WE) begin
      m_data[TCAM_WR_ADDR] <= TCAM_DIN;
      m_mask[TCAM_WR_ADDR] <= TCAM_DATA_MASK;
      m_vld[TCAM_WR_ADDR]  <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always_comb begin
    TCAM_MATCH = 1'b0;
    TCAM_MATCH_ADDR = '0;
    for (int i = 15; i >= 0; i--)
      if (m_vld[i] && (((TCAM_CMP_DIN ^ m_data[i]) & ~m_mask[i]) == '0)) begin
        TCAM_MATCH = 1'b1;
        TCAM_MATCH_ADDR = AW'(i);
      end
  end

  function automatic rsp_t ref_lu(input logic [DW-1:0] key, input logic [TW-1:0] tag);
    for (int i = 0; i < 16; i++)
      if (m_vld[i] && (((key ^ m_data[i]) & ~m_mask[i]) == '0)) return {1'b1, AW'(i), tag};
    return {1'b0, {AW{1'b0}}, tag};
  endfunction

  int   tests = 0, fails = 0, cyc = 0;
  int   m_hits = 0, m_misses = 0;
  rsp_t exp_q[$], got_q[$];
  int   rsp_cyc[$];
  logic acc, wacc, rsp_now, we_seen, lu_rdy, wr_rdy, rsp_v;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_din, s_mask;

  task automatic tick();
    rsp_t e;
    @(negedge CLK);
    acc = 1'b0; wacc = 1'b0;
    if (!RESET && LU_REQ_VALID && LU_REQ_READY) begin
      e = ref_lu(LU_REQ_KEY, LU_REQ_TAG);
      exp_q.push_back(e);
      if (e[AW+TW]) m_hits++; else m_misses++;
      acc = 1'b1;
    end
    if (!RESET && WR_REQ_VALID && WR_REQ_READY) wacc = 1'b1;
    rsp_now = !RESET && LU_RSP_VALID && LU_RSP_READY;
    if (rsp_now) begin got_q.push_back({LU_RSP_HIT, LU_RSP_ADDR, LU_RSP_TAG}); rsp_cyc.push_back(cyc); end
    we_seen = TCAM_WE; lu_rdy = LU_REQ_READY; wr_rdy = WR_REQ_READY; rsp_v = LU_RSP_VALID;
    s_wr_addr = TCAM_WR_ADDR; s_din = TCAM_DIN; s_mask = TCAM_DATA_MASK;
    cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m, input int bl);
    int n;
    busy_len = bl;
    WR_REQ_VALID = 1'b1; WR_REQ_ADDR = a; WR_REQ_DATA = d; WR_REQ_MASK = m;
    n = 0;
    do begin tick(); n++; end while (!wacc && n < 50);
    WR_REQ_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!lu_rdy && n < 60);
    tests++;
    if (!lu_rdy) begin fails++; $display("FAIL write_complete: lu_ready=%0d required 1 within 60 cycles", lu_rdy); end
  endtask

  task automatic test_reset();
    RESET = 1'b1; WR_REQ_VALID = 0; LU_REQ_VALID = 0; LU_RSP_READY = 0;
    WR_REQ_ADDR = 0; WR_REQ_DATA = 0; WR_REQ_MASK = 0; LU_REQ_KEY = 0; LU_REQ_TAG = 0;
    tick(); tick();
    tests++; if (lu_rdy !== 1'b0) begin fails++; $display("FAIL reset_lu_ready: got %0d want 0", lu_rdy); end
    RESET = 1'b0;
    tick();
    tests++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0d want 0", rsp_v); end
    tests++; if (we_seen !== 1'b0) begin fails++; $display("FAIL reset_we: got %0d want 0", we_seen); end
    tests++; if (HIT_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", HIT_COUNT, MISS_COUNT); end
    tests++; if (TCAM_CMP_DIN !== '0 || TCAM_CMP_DATA_MASK !== '0) begin fails++; $display("FAIL reset_cmp: got %h/%h want 0/0", TCAM_CMP_DIN, TCAM_CMP_DATA_MASK); end
    tests++; if (lu_rdy !== 1'b1) begin fails++; $display("FAIL idle_lu_ready: got %0d want 1", lu_rdy); end
  endtask

  task automatic test_write_busy();
    int n, we_cnt, first_we, first_rdy;
    busy_len = 16;
    WR_REQ_VALID = 1'b1; WR_REQ_ADDR = 4'd3; WR_REQ_DATA = 16'h00AB; WR_REQ_MASK = 16'hFF00;
    n = 0;
    do begin tick(); n++; end while (!wacc && n < 20);
    tests++; if (!wacc) begin fails++; $display("FAIL write_accept: got 0 want 1 within 20 cycles"); end
    WR_REQ_VALID = 1'b0;
    we_cnt = 0; first_we = -1; first_rdy = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (we_seen) begin
        we_cnt++;
        if (first_we < 0) first_we = i;
        tests++;
        if (s_wr_addr !== 4'd3 || s_din !== 16'h00AB || s_mask !== 16'hFF00) begin
          fails++; $display("FAIL write_fields: got %h/%h/%h want 3/00ab/ff00", s_wr_addr, s_din, s_mask);
        end
      end
      if (lu_rdy && first_rdy < 0) first_rdy = i;
    end
    tests++; if (we_cnt != 1) begin fails++; $display("FAIL we_pulses: got %0d want 1", we_cnt); end
    tests++; if (first_we != 0) begin fails++; $display("FAIL we_timing: got %0d want 0", first_we); end
    tests++; if (first_rdy != busy_len + 2) begin fails++; $display("FAIL ready_after_busy: got %0d want %0d", first_rdy, busy_len + 2); end
  endtask

  task automatic test_hit_lookup();
    int first_rsp;
    exp_q.delete(); got_q.delete();
    LU_RSP_READY = 1'b1; LU_REQ_VALID = 1'b1; LU_REQ_KEY = 16'h12AB; LU_REQ_TAG = 8'h5A;
    tick();
    tests++; if (!acc) begin fails++; $display("FAIL hit_accept: got 0 want 1"); end
    LU_REQ_VALID = 1'b0;
    first_rsp = -1;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_v && first_rsp < 0) first_rsp = i; end
    tests++; if (first_rsp != 1) begin fails++; $display("FAIL rsp_latency: got %0d want 1", first_rsp); end
    tests++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 4'd3, 8'h5A}) begin
      fails++; $display("FAIL hit_rsp: got n=%0d %h want n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : rsp_t'(0), {1'b1, 4'd3, 8'h5A});
    end
    tests++; if (HIT_COUNT !== 32'd1 || MISS_COUNT !== 32'd0) begin fails++; $display("FAIL hit_counts: got %0d/%0d want 1/0", HIT_COUNT, MISS_COUNT); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4], wm [4];
    int acc_cnt, j;
    for (int i = 0; i < 4; i++) begin
      wa[i] = AW'(4 + i * 3); wd[i] = DW'($urandom); wm[i] = DW'($urandom) & 16'h0F0F;
      do_write(wa[i], wd[i], wm[i], $urandom_range(0, 3));
    end
    exp_q.delete(); got_q.delete(); rsp_cyc.delete();
    LU_RSP_READY = 1'b1; LU_REQ_VALID = 1'b1; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      j = $urandom_range(0, 3);
      LU_REQ_KEY = (i % 2 == 0) ? (wd[j] ^ (DW'($urandom) & wm[j])) : DW'($urandom);
      LU_REQ_TAG = TW'(8'h10 + i);
      tick();
      if (acc) acc_cnt++;
    end
    LU_REQ_VALID = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (acc_cnt != 8) begin fails++; $display("FAIL b2b_accepts: got %0d want 8", acc_cnt); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    tests++;
    if (rsp_cyc.size() != 8 || rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[0] != 7) begin
      fails++; $display("FAIL b2b_rate: got %0d responses want 8 over 8 consecutive cycles", rsp_cyc.size());
    end
    tests++; if (HIT_COUNT !== 32'(m_hits) || MISS_COUNT !== 32'(m_misses)) begin fails++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", HIT_COUNT, MISS_COUNT, m_hits, m_misses); end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    exp_q.delete(); got_q.delete();
    LU_RSP_READY = 1'b0; LU_REQ_VALID = 1'b1; LU_REQ_TAG = 8'h40; LU_REQ_KEY = DW'($urandom);
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc) begin acc_cnt++; LU_REQ_TAG = LU_REQ_TAG + 8'd1; LU_REQ_KEY = DW'($urandom); end
    end
    tests++; if (acc_cnt != 4) begin fails++; $display("FAIL bp_accepts: got %0d want 4", acc_cnt); end
    tests++; if (lu_rdy !== 1'b0) begin fails++; $display("FAIL bp_ready: got %0d want 0", lu_rdy); end
    tests++; if (LU_RSP_VALID !== 1'b1 || LU_RSP_TAG !== 8'h40) begin fails++; $display("FAIL bp_hold: got v=%0d tag=%h want v=1 tag=40", LU_RSP_VALID, LU_RSP_TAG); end
    LU_REQ_VALID = 1'b0; LU_RSP_READY = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL bp_drain: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_q[i][TW-1:0] !== TW'(8'h40 + i)) begin
        fails++; $display("FAIL bp_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++; if (HIT_COUNT !== 32'(m_hits) || MISS_COUNT !== 32'(m_misses)) begin fails++; $display("FAIL bp_counts: got %0d/%0d want %0d/%0d", HIT_COUNT, MISS_COUNT, m_hits, m_misses); end
  endtask

  task automatic test_priority();
    int n, lu_cnt, w_idx, lu_during_wr;
    logic first_wr_rdy;
    exp_q.delete(); got_q.delete();
    LU_RSP_READY = 1'b1; LU_REQ_VALID = 1'b1; LU_REQ_TAG = 8'h70; LU_REQ_KEY = DW'($urandom);
    lu_cnt = 0; n = 0;
    while (lu_cnt < 2 && n < 20) begin
      tick(); n++;
      if (acc) begin lu_cnt++; LU_REQ_TAG = LU_REQ_TAG + 8'd1; LU_REQ_KEY = DW'($urandom); end
    end
    busy_len = 2;
    WR_REQ_VALID = 1'b1; WR_REQ_ADDR = 4'd0; WR_REQ_DATA = 16'h5555; WR_REQ_MASK = 16'h0000;
    LU_REQ_KEY = 16'h5555; LU_REQ_TAG = 8'h77;
    w_idx = -1; lu_during_wr = 0; first_wr_rdy = 1'bx;
    for (int i = 0; i < 20 && w_idx < 0; i++) begin
      tick();
      if (i == 0) first_wr_rdy = wr_rdy;
      if (acc) lu_during_wr++;
      if (wacc) w_idx = i;
    end
    WR_REQ_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!acc && n < 40);
    LU_REQ_VALID = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++; if (first_wr_rdy !== 1'b0) begin fails++; $display("FAIL prio_wait_pipe: got %0d want 0", first_wr_rdy); end
    tests++; if (w_idx != 1) begin fails++; $display("FAIL prio_write_cycle: got %0d want 1", w_idx); end
    tests++; if (lu_during_wr != 0) begin fails++; $display("FAIL prio_lu_held: got %0d want 0", lu_during_wr); end
    tests++;
    if (got_q.size() != 3 || got_q[2] !== {1'b1, 4'd0, 8'h77} || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      fails++; $display("FAIL prio_rsp: got n=%0d last=%h want n=3 last=%h", got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : rsp_t'(0), {1'b1, 4'd0, 8'h77});
    end
  endtask

  task automatic test_reset_mid();
    int n, lu_cnt;
    LU_RSP_READY = 1'b0; LU_REQ_VALID = 1'b1; LU_REQ_TAG = 8'h90;
    lu_cnt = 0; n = 0;
    while (lu_cnt < 3 && n < 20) begin
      tick(); n++;
      if (acc) begin lu_cnt++; LU_REQ_TAG = LU_REQ_TAG + 8'd1; end
    end
    LU_REQ_VALID = 1'b0;
    tick(); tick();
    tests++; if (!rsp_v) begin fails++; $display("FAIL mid_buffered: got 0 want 1"); end
    RESET = 1'b1;
    tick();
    tests++; if (LU_RSP_VALID !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %0d want 0", LU_RSP_VALID); end
    tests++; if (HIT_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin fails++; $display("FAIL mid_counts: got %0d/%0d want 0/0", HIT_COUNT, MISS_COUNT); end
    RESET = 1'b0; m_hits = 0; m_misses = 0; exp_q.delete(); got_q.delete();
    tick();
    busy_len = 5;
    WR_REQ_VALID = 1'b1; WR_REQ_ADDR = 4'd5; WR_REQ_DATA = 16'hBEEF; WR_REQ_MASK = 16'h0;
    n = 0;
    do begin tick(); n++; end while (!wacc && n < 20);
    WR_REQ_VALID = 1'b0;
    tests++; if (TCAM_WE !== 1'b1) begin fails++; $display("FAIL mid_we_high: got %0d want 1", TCAM_WE); end
    RESET = 1'b1;
    tick();
    tests++; if (TCAM_WE !== 1'b0) begin fails++; $display("FAIL mid_we_drop: got %0d want 0", TCAM_WE); end
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (lu_rdy !== 1'b1) begin fails++; $display("FAIL mid_recover: got %0d want 1", lu_rdy); end
  endtask

  initial begin
    test_reset();
    test_write_busy();
    test_hit_lookup();
    test_back_to_back();
    test_backpressure();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
